// File: rtl/ysyx_25070198_lsu_pkg.sv
// Shared types and lane helpers for the multi-cycle load/store unit.
// Misalignment helper is consumed only when YSYX_25070198_LSU_MISALIGN_CHK_EN is defined.
package ysyx_25070198_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Size 3 is treated as a word access everywhere.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    lane_mask = base << off;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25070198_lsu_align.sv
// Byte-lane alignment: store mask/shift and load shift with sign/zero extension.
module ysyx_25070198_lsu_align
  import ysyx_25070198_lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_sh;
  logic [31:0] w_rsh;

  assign w_sh    = {i_off, 3'b000};
  assign o_wmask = lane_mask(i_size, i_off);
  assign o_wdata = i_wdata << w_sh;
  assign w_rsh   = i_rdata >> w_sh;

  always_comb begin
    o_rdata = w_rsh;
    case (i_size)
      SZ_B:    o_rdata = {{24{~i_unsigned & w_rsh[7]}}, w_rsh[7:0]};
      SZ_H:    o_rdata = {{16{~i_unsigned & w_rsh[15]}}, w_rsh[15:0]};
      default: o_rdata = w_rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_25070198_lsu.sv
// Multi-cycle LSU: EXU request -> memory handshake with timeout -> WBU response.
// Define YSYX_25070198_LSU_MISALIGN_CHK_EN to fault misaligned half/word accesses without a memory access.
module ysyx_25070198_lsu
  import ysyx_25070198_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned RD_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wen,
  output logic [RD_W-1:0]   rsp_rd,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        r_state, w_next;
  logic              r_we, r_unsigned, r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;
  logic [RD_W-1:0]   r_rd;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_timeout, w_mis;
  logic [3:0]        w_st_mask;
  logic [31:0]       w_st_data, w_ld_data;
  logic [31:0]       w_unused_req_rdata, w_unused_rsp_wdata;
  logic [3:0]        w_unused_rsp_wmask;

  assign w_timeout = (r_cnt == CNT_LAST);

`ifdef YSYX_25070198_LSU_MISALIGN_CHK_EN
  assign w_mis = misaligned(req_size, req_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // rvalid is checked before the timeout so a same-cycle response wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next = w_mis ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_gnt) w_next = ST_WAIT;
      ST_WAIT: if (mem_rvalid || w_timeout) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_we       <= req_we;
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
          r_addr     <= req_addr;
          r_wdata    <= req_wdata;
          r_rd       <= req_rd;
          r_err      <= w_mis;
          r_rdata    <= '0;
        end
        ST_REQ: if (mem_gnt) r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (mem_rvalid) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? '0 : w_ld_data;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  ysyx_25070198_lsu_align u_req_align (
    .i_size     (r_size),
    .i_off      (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    ('0),
    .o_wmask    (w_st_mask),
    .o_wdata    (w_st_data),
    .o_rdata    (w_unused_req_rdata)
  );

  ysyx_25070198_lsu_align u_rsp_align (
    .i_size     (r_size),
    .i_off      (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_wdata    ('0),
    .i_rdata    (mem_rdata),
    .o_wmask    (w_unused_rsp_wmask),
    .o_wdata    (w_unused_rsp_wdata),
    .o_rdata    (w_ld_data)
  );

  // Outputs are gated by state so that reset zeroes them without a clock edge.
  assign req_ready = (r_state == ST_IDLE);
  assign mem_req   = (r_state == ST_REQ);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? r_addr[ADDR_W-1:2] : '0;
  assign mem_wmask = mem_we ? w_st_mask : '0;
  assign mem_wdata = mem_req ? w_st_data : '0;

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_wen   = rsp_valid & ~r_we & ~r_err & (r_rd != '0);
  assign rsp_rd    = rsp_valid ? r_rd : '0;
  assign rsp_rdata = rsp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_ysyx_25070198_lsu.sv
// Self-checking bench for ysyx_25070198_lsu: directed vector table, reset sequences, randomized accesses.
module tb_ysyx_25070198_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid, rsp_wen, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  ysyx_25070198_lsu #(.ADDR_W(32), .TIMEOUT_CYC(T), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wen(rsp_wen), .rsp_rd(rsp_rd),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_cyc;
    int          rdy_dly;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_wen;
    logic        e_mis;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                              input logic [31:0] rdata, input int gd, input int rv, input int rdy,
                              input logic [3:0] mask, input logic [31:0] ewd, input logic [31:0] erd,
                              input logic err, input logic wen, input logic mis);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.gnt_dly = gd; v.rv_cyc = rv; v.rdy_dly = rdy;
    v.e_mask = mask; v.e_wdata = ewd; v.e_rdata = erd; v.e_err = err; v.e_wen = wen; v.e_mis = mis;
    return v;
  endfunction

  // Reference model: byte-by-byte lane placement and extension.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          n;
    int          off;
    logic [7:0]  b[4];
    logic [31:0] val;
    r   = v;
    n   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    off = int'(v.addr[1:0]);
    r.e_mask  = '0;
    r.e_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) r.e_mask[i] = 1'b1;
      if (i >= off) r.e_wdata[8*i +: 8] = v.wdata[8*(i-off) +: 8];
      b[i] = 8'h00;
      if (i + off < 4) b[i] = v.rdata[8*(i+off) +: 8];
    end
    if (!v.we) r.e_mask = '0;
    if (n == 1) begin
      val = {24'h0, b[0]};
      if (!v.uns && b[0][7]) val = val | 32'hFFFFFF00;
    end else if (n == 2) begin
      val = {16'h0, b[1], b[0]};
      if (!v.uns && b[1][7]) val = val | 32'hFFFF0000;
    end else begin
      val = {b[3], b[2], b[1], b[0]};
    end
    r.e_mis = 1'b0;
`ifdef YSYX_25070198_LSU_MISALIGN_CHK_EN
    r.e_mis = (n == 2 && (off % 2) == 1) || (n == 4 && off != 0);
`endif
    r.e_err   = r.e_mis || !(v.rv_cyc >= 1 && v.rv_cyc <= T);
    r.e_rdata = (v.we || r.e_err) ? 32'h0 : val;
    r.e_wen   = !v.we && !r.e_err && (v.rd != 5'd0);
    return r;
  endfunction

  // Drives one request, acts as memory with the given delays, checks every phase.
  task automatic do_access(input vec_t v);
    int wait_n;
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    tick;
    req_valid = 1'b0; req_wdata = $urandom; req_rd = 5'($urandom);
    chk1("req_ready_busy", req_ready, 1'b0);
    if (v.e_mis) begin
      chk1("mis_no_mem_req", mem_req, 1'b0);
    end else begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        chk1("mem_req", mem_req, 1'b1);
        chk1("mem_we", mem_we, v.we);
        chk("mem_addr", {2'b00, mem_addr}, {2'b00, v.addr[31:2]});
        chk("mem_wmask", {28'h0, mem_wmask}, {28'h0, v.e_mask});
        if (v.we) chk("mem_wdata", mem_wdata, v.e_wdata);
        mem_gnt = (k == v.gnt_dly);
        tick;
      end
      mem_gnt = 1'b0;
      wait_n = (v.rv_cyc >= 1 && v.rv_cyc <= T) ? v.rv_cyc : T;
      for (int w = 1; w <= wait_n; w++) begin
        chk1("mem_req_wait", mem_req, 1'b0);
        chk1("rsp_valid_wait", rsp_valid, 1'b0);
        mem_rvalid = (w == v.rv_cyc);
        mem_rdata  = (mem_rvalid && !v.we) ? v.rdata : $urandom;
        tick;
      end
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    for (int r = 0; r <= v.rdy_dly; r++) begin
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk1("rsp_err", rsp_err, v.e_err);
      chk1("rsp_wen", rsp_wen, v.e_wen);
      chk("rsp_rd", {27'h0, rsp_rd}, {27'h0, v.rd});
      chk("rsp_rdata", rsp_rdata, v.e_rdata);
      chk1("req_ready_resp", req_ready, 1'b0);
      chk1("mem_req_resp", mem_req, 1'b0);
      rsp_ready = (r == v.rdy_dly);
      tick;
    end
    rsp_ready = 1'b0;
    chk1("rsp_valid_done", rsp_valid, 1'b0);
    chk1("req_ready_done", req_ready, 1'b1);
  endtask

  task automatic issue_load(input logic [31:0] addr);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = addr; req_rd = 5'd4;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic pulse_reset;
    #2 rst = 1'b0;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    @(negedge clk) rst = 1'b1;
  endtask

  vec_t tbl[11];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(1'b1, 2'd0, 1'b0, 32'h80000003, 32'h000000AB, 5'd1, 32'h0, 0, 1, 0,
                4'b1000, 32'hAB000000, 32'h0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 2'd0, 1'b0, 32'h80000001, 32'h0, 5'd10, 32'h1234F600, 0, 1, 0,
                4'b0000, 32'h0, 32'hFFFFFFF6, 1'b0, 1'b1, 1'b0);
    tbl[2] = mk(1'b0, 2'd0, 1'b1, 32'h80000001, 32'h0, 5'd10, 32'h1234F600, 0, 1, 0,
                4'b0000, 32'h0, 32'h000000F6, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 2'd1, 1'b0, 32'h80000002, 32'h0, 5'd7, 32'h80010000, 3, 1, 2,
                4'b0000, 32'h0, 32'hFFFF8001, 1'b0, 1'b1, 1'b0);
    tbl[4] = mk(1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 5'd3, 32'h0, 0, 0, 0,
                4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tbl[5] = mk(1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 5'd3, 32'h13579BDF, 0, 4, 1,
                4'b0000, 32'h0, 32'h13579BDF, 1'b0, 1'b1, 1'b0);
`ifdef YSYX_25070198_LSU_MISALIGN_CHK_EN
    tbl[6] = mk(1'b0, 2'd2, 1'b0, 32'h80000002, 32'h0, 5'd4, 32'h0, 0, 1, 0,
                4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    tbl[7] = mk(1'b1, 2'd1, 1'b0, 32'h80000003, 32'h0000BEEF, 5'd2, 32'h0, 0, 1, 0,
                4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
`else
    tbl[6] = mk(1'b1, 2'd1, 1'b0, 32'h80000003, 32'h0000BEEF, 5'd2, 32'h0, 1, 2, 0,
                4'b1000, 32'hEF000000, 32'h0, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(1'b0, 2'd1, 1'b0, 32'h80000003, 32'h0, 5'd6, 32'hAB000000, 0, 1, 0,
                4'b0000, 32'h0, 32'h000000AB, 1'b0, 1'b1, 1'b0);
`endif
    tbl[8] = mk(1'b1, 2'd2, 1'b0, 32'h80000010, 32'h11223344, 5'd0, 32'h0, 2, 2, 1,
                4'b1111, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b0);
    tbl[9] = mk(1'b0, 2'd2, 1'b0, 32'h80000008, 32'h0, 5'd0, 32'hCAFEF00D, 1, 2, 0,
                4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 2'd1, 1'b0, 32'h80000002, 32'h1234ABCD, 5'd9, 32'h0, 0, 1, 0,
                 4'b1100, 32'hABCD0000, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset state is visible before any clock edge.
    #1;
    chk1("init_req_ready", req_ready, 1'b1);
    chk1("init_mem_req", mem_req, 1'b0);
    chk1("init_rsp_valid", rsp_valid, 1'b0);
    chk("init_rsp_rdata", rsp_rdata, 32'h0);
    tick; tick;
    @(negedge clk) rst = 1'b1;
    tick;

    for (int i = 0; i < 11; i++) do_access(tbl[i]);

    // Reset while in REQ drops mem_req immediately.
    issue_load(32'h80000020);
    chk1("pre_rst_mem_req", mem_req, 1'b1);
    pulse_reset();
    tick;
    chk1("post_rst_idle", mem_req, 1'b0);

    // Reset while in WAIT; a late rvalid in IDLE is ignored.
    issue_load(32'h80000024);
    mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
    chk1("wait_no_mem_req", mem_req, 1'b0);
    pulse_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    tick;
    mem_rvalid = 1'b0;
    chk1("late_rvalid_rsp_valid", rsp_valid, 1'b0);
    chk1("late_rvalid_req_ready", req_ready, 1'b1);
    chk1("late_rvalid_mem_req", mem_req, 1'b0);

    // Reset while presenting a timeout error response.
    issue_load(32'h80000028);
    mem_gnt = 1'b1; tick; mem_gnt = 1'b0;
    for (int w = 0; w < T; w++) tick;
    chk1("pre_rst_rsp_valid", rsp_valid, 1'b1);
    chk1("pre_rst_rsp_err", rsp_err, 1'b1);
    pulse_reset();
    tick;

    do_access(mk(1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0, 5'd11, 32'hDEADBEEF, 0, 1, 0,
                 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0));

    for (int i = 0; i < 40; i++) begin
      v.we      = 1'($urandom_range(0, 1));
      v.size    = 2'($urandom_range(0, 3));
      v.uns     = 1'($urandom_range(0, 1));
      v.addr    = 32'h80000000 | ($urandom & 32'h000000FF);
      v.wdata   = $urandom;
      v.rd      = 5'($urandom);
      v.rdata   = $urandom;
      v.gnt_dly = int'($urandom_range(0, 3));
      v.rv_cyc  = int'($urandom_range(1, 5));
      v.rdy_dly = int'($urandom_range(0, 2));
      do_access(model(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_25070198_lsu.md
Name: ysyx_25070198_lsu

Overview:
- Multi-cycle load/store unit; successor to the single-cycle lw/lbu/sw/sb path.
- Sits between EXU and data memory, and between memory and the register-file write port.
- Supports byte, half and word accesses with sign or zero extension, a variable-latency memory handshake and a bus timeout.
- Parametrised in address width and timeout.

Parameters:
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits.
- TIMEOUT_CYC, 255, maximum cycles in WAIT before an error response; minimum 1.
- RD_W, 5, destination-register index width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid  in  1  EXU request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  RD_W  load destination register
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W-2  word address
- mem_wmask  out  4  byte-lane write mask
- mem_wdata  out  32  lane-shifted store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid / write acknowledge
- mem_rdata  in  32  read word
- rsp_valid  out  1  response valid
- rsp_ready  in  1  WBU accepts response
- rsp_wen  out  1  register write required (load, no error, rd != 0)
- rsp_rd  out  RD_W  destination register
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access fault (timeout or misalignment)

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- Reset (rst=0): immediately, regardless of state:
  - state forced to IDLE;
  - all outputs 0 except req_ready, which is 1 after reset;
  - any in-flight access is abandoned; a late mem_rvalid arriving after reset in IDLE is ignored.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we, size, unsigned, addr, wdata and rd; go to REQ.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_wmask and mem_wdata are stable until mem_gnt.
  - On mem_gnt: deassert mem_req next cycle; go to WAIT; clear the timeout counter.
  - Loads drive mem_wmask=0.
- WAIT:
  - Counter increments each cycle.
  - mem_rvalid → capture data and go to RESP with err=0.
  - Counter == TIMEOUT_CYC-1 without rvalid → go to RESP with err=1 and rdata=0.
  - rvalid on the same cycle as the timeout wins (no error).
- RESP:
  - rsp_valid=1; all rsp_* fields held stable until rsp_ready.
  - On rsp_ready: go to IDLE.
  - req_ready=0 in every state except IDLE (no overlap).
- mem_rvalid is sampled only in WAIT. Memory must not assert rvalid in the same cycle as gnt.
- Latency with zero-wait memory (gnt in the first REQ cycle, rvalid the next cycle): request handshake at cycle 0, mem_req at cycle 1, rvalid at cycle 2, rsp_valid at cycle 3.
- Lane logic, with off = addr[1:0]:
  - mask = (size0: 4'b0001, size1: 4'b0011, size2: 4'b1111) << off, truncated to 4 bits.
  - wdata = req_wdata << (8*off).
  - load data = mem_rdata >> (8*off), then sign- or zero-extended from 8/16 bits; word loads pass through.

Optional Feature:
- Macro: YSYX_25070198_LSU_MISALIGN_CHK_EN.
- Defined: a half access with off=1 or 3, or a word access with off != 0, skips REQ/WAIT. The FSM goes IDLE→RESP in one cycle with rsp_err=1, rsp_wen=0, rsp_rdata=0, and no memory access occurs.
- Undefined: no check is made. The mask is truncated as above (e.g. half at off=3 writes lane 3 only), and load bytes shifted past lane 3 read as 0 before extension.

Decomposition:
- Shared package ysyx_25070198_lsu_pkg:
  - state encoding (2-bit IDLE=0, REQ=1, WAIT=2, RESP=3);
  - size encodings SZ_B/SZ_H/SZ_W;
  - functions lane_mask(size, off) and misaligned(size, off).
- One combinational sub-module, ysyx_25070198_lsu_align: store mask/shift and load shift/extend. Used once on the request side and once on the response side.

Test Plan:
- sb, addr=0x80000003, wdata=0x000000AB, zero-wait memory → mem_addr=0x20000000, mem_wmask=4'b1000, mem_wdata=0xAB000000; rsp_valid at cycle 3 with rsp_wen=0, rsp_err=0.
- lb then lbu at addr=0x80000001, mem_rdata=0x1234F600 → rsp_rdata=0xFFFFFFF6 and 0x000000F6 respectively; rsp_wen=1, rsp_rd=10.
- lh at addr=0x80000002, mem_rdata=0x8001_0000, gnt delayed 3 cycles, rsp_ready held low 2 cycles → mem_req high for exactly 4 cycles; rsp_rdata=0xFFFF8001 held stable; req_ready=0 until the response handshake.
- TIMEOUT_CYC=4, load with no rvalid → rsp_err=1, rsp_rdata=0, rsp_wen=0; rsp_valid asserted 4 cycles after gnt. Repeat with rvalid arriving exactly on the 4th WAIT cycle → rsp_err=0.
- rst pulled low while in WAIT → mem_req, rsp_valid and rsp_err go to 0 with no clock edge. After release, req_ready=1, and a subsequent lw to 0x80000010 returning mem_rdata=0xDEADBEEF completes normally.
- With MISALIGN_CHK_EN defined: lw to 0x80000002 → mem_req never asserted; rsp_valid at cycle 1 with rsp_err=1. Without it: sh to 0x80000003, wdata=0xBEEF → mem_wmask=4'b1000, mem_wdata=0xEF000000.
